cache_mem_responder: RTL

//  Responder (slave) end of the cache miss interface: accepts rd_req/wr_req from one cache
//  and serves them from a synchronous word SRAM. Returns line refills as 4 ret_valid beats.

---
 rtl/cache_mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// Responder end of the cache miss interface: serves line/word reads and drains
// line/word writes against a synchronous 32-bit word SRAM, one word per cycle.
module cache_mem_responder #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_RD_END, S_WR} state_t;

    localparam logic [3:0] LAT_LAST = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [3:0]          lat_q, lat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                line_q, line_d;
    logic [3:0]          we_q, we_d;
    logic [127:0]        data_q, data_d;
    logic                ret_valid_q, ret_valid_d;
    logic                ret_last_q, ret_last_d;
    logic [31:0]         ret_hold_q, ret_hold_d;
    logic                last_beat;
    logic                rd_line, wr_line;

    // Address bits above the SRAM and below the word are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    assign rd_line   = (rd_type == 3'b100);
    assign wr_line   = (wr_type == 3'b100);
    assign last_beat = line_q ? (cnt_q == 2'd3) : 1'b1;

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        line_d      = line_q;
        we_d        = we_q;
        data_d      = data_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        ret_hold_d  = ret_valid_q ? mem_rdata : ret_hold_q;

        wr_rdy    = ready_q && (state_q == S_IDLE);
        rd_rdy    = wr_rdy && !wr_req;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = {addr_q[ADDR_W-1:2], addr_q[1:0] | cnt_q};
        mem_wdata = data_q[{cnt_q, 5'd0} +: 32];

        case (state_q)
            S_IDLE: begin
                if (wr_req && wr_rdy) begin
                    line_d  = wr_line;
                    addr_d  = {wr_addr[ADDR_W+1:4], wr_line ? 2'b00 : wr_addr[3:2]};
                    we_d    = wr_line ? 4'hf : wr_wstrb;
                    data_d  = wr_data;
                    cnt_d   = 2'd0;
                    state_d = S_WR;
                end else if (rd_req && rd_rdy) begin
                    line_d  = rd_line;
                    addr_d  = {rd_addr[ADDR_W+1:4], rd_line ? 2'b00 : rd_addr[3:2]};
                    cnt_d   = 2'd0;
                    lat_d   = 4'd0;
                    state_d = (RD_LAT > 0) ? S_WAIT : S_RD;
                end
            end
            S_WAIT: begin
                lat_d = lat_q + 4'd1;
                if (lat_q == LAT_LAST) state_d = S_RD;
            end
            S_RD: begin
                mem_en      = 1'b1;
                ret_valid_d = 1'b1;
                ret_last_d  = last_beat;
                cnt_d       = cnt_q + 2'd1;
                if (last_beat) begin
                    cnt_d   = 2'd0;
                    state_d = S_RD_END;
                end
            end
            // Final read beat is still on ret_* here, so stay unready one more cycle.
            S_RD_END: state_d = S_IDLE;
            S_WR: begin
                mem_en = 1'b1;
                mem_we = we_q;
                cnt_d  = cnt_q + 2'd1;
                if (last_beat) begin
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            cnt_q       <= 2'd0;
            lat_q       <= 4'd0;
            addr_q      <= '0;
            line_q      <= 1'b0;
            we_q        <= 4'h0;
            data_q      <= '0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_hold_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            we_q        <= we_d;
            data_q      <= data_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_hold_q  <= ret_hold_d;
        end
    end

    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign ret_data  = ret_valid_q ? mem_rdata : ret_hold_q;

endmodule
